// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter
//   Four-requester register-file write arbiter. One requester is granted per
//   cycle (combinational one-hot gnt); the winner's destination/data are
//   registered and presented to the register file on the following cycle.
//   Writes to register 0 are granted but suppressed (rf_we stays low).
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[3:0]     write requests, bit i = requester i
//   dst0..dst3   destination register number per requester
//   data0..data3 write data per requester
//   gnt[3:0]     one-hot grant, combinational, same cycle as the winning req
//   sel[1:0]     registered index of the last winner
//   rf_we        registered register-file write enable
//   rf_waddr     registered write address
//   rf_wdata     registered write data
//   conflict     registered; 1 when the previous cycle had >= 2 requests
//
// Configuration
//   REGWRITE_FIXED_PRIO_EN  defined: fixed priority, lowest index wins, no
//                           round-robin pointer. Undefined: round-robin.

module regwrite_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [4:0]  dst0,
    input  logic [4:0]  dst1,
    input  logic [4:0]  dst2,
    input  logic [4:0]  dst3,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        conflict
);

    logic        any;
    logic [1:0]  win;
    logic [4:0]  win_dst;
    logic [31:0] win_data;
    logic        multi;

`ifndef REGWRITE_FIXED_PRIO_EN
    // Index of the last winner; the search starts one above it.
    logic [1:0]  ptr;
    logic [1:0]  idx;
`endif

    always_comb begin
        any = 1'b0;
        win = '0;
`ifdef REGWRITE_FIXED_PRIO_EN
        for (int unsigned i = 0; i < 4; i++) begin
            if (!any && req[i]) begin
                any = 1'b1;
                win = 2'(i);
            end
        end
`else
        idx = '0;
        // k = 4 wraps to ptr itself, so the last winner is considered last.
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
`endif
        // No grants while held in reset.
        if (!rst_n) begin
            any = 1'b0;
        end
        gnt = any ? (4'b0001 << win) : '0;
    end

    always_comb begin
        win_dst  = '0;
        win_data = '0;
        case (win)
            2'd0: begin win_dst = dst0; win_data = data0; end
            2'd1: begin win_dst = dst1; win_data = data1; end
            2'd2: begin win_dst = dst2; win_data = data2; end
            default: begin win_dst = dst3; win_data = data3; end
        endcase
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi = |(req & (req - 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            conflict <= 1'b0;
`ifndef REGWRITE_FIXED_PRIO_EN
            ptr      <= 2'd3;
`endif
        end else begin
            conflict <= multi;
            // Register 0 is hard-wired zero: grant it but never write it.
            rf_we    <= any && (win_dst != 5'd0);
            if (any) begin
                sel      <= win;
                rf_waddr <= win_dst;
                rf_wdata <= win_data;
`ifndef REGWRITE_FIXED_PRIO_EN
                ptr      <= win;
`endif
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: a behavioural model checked every
// negative clock edge, plus directed scenarios with literal expectations.

module tb_regwrite_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [4:0]  dsts  [4];
    logic [31:0] datas [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        conflict;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state
    int          m_ptr;
    logic        m_we;
    logic [1:0]  m_sel;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_conf;

    logic [3:0]  exp_rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  tbl [12] = '{4'b0001, 4'b0011, 4'b0011, 4'b1100, 4'b0000, 4'b1001,
                              4'b1111, 4'b0110, 4'b0101, 4'b1010, 4'b0000, 4'b1110};

    always #5 clk = ~clk;

    regwrite_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .dst0     (dsts[0]),
        .dst1     (dsts[1]),
        .dst2     (dsts[2]),
        .dst3     (dsts[3]),
        .data0    (datas[0]),
        .data1    (datas[1]),
        .data2    (datas[2]),
        .data3    (datas[3]),
        .gnt      (gnt),
        .sel      (sel),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .conflict (conflict)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner index by the arbitration rule, -1 if nobody requests.
    function automatic int pick(input logic [3:0] r, input int p);
`ifdef REGWRITE_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        int w;
        w = pick(req, m_ptr);
        if (rst_n !== 1'b1 || w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 3;
            m_we    <= 1'b0;
            m_sel   <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_conf  <= 1'b0;
        end else begin
            m_conf <= ($countones(req) >= 2);
            m_we   <= (pick(req, m_ptr) >= 0) && (dsts[pick(req, m_ptr)] != 5'd0);
            if (pick(req, m_ptr) >= 0) begin
                m_sel   <= 2'(pick(req, m_ptr));
                m_waddr <= dsts[pick(req, m_ptr)];
                m_wdata <= datas[pick(req, m_ptr)];
                m_ptr   <= pick(req, m_ptr);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_gnt",      gnt,      exp_gnt());
            chk("m_sel",      sel,      m_sel);
            chk("m_rf_we",    rf_we,    m_we);
            chk("m_rf_waddr", rf_waddr, m_waddr);
            chk("m_rf_wdata", rf_wdata, m_wdata);
            chk("m_conflict", conflict, m_conf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < 4; i++) begin
            dsts[i]  = '0;
            datas[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_we",    rf_we,    0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_sel",      sel,      0);
        chk("reset_conflict", conflict, 0);
        req = 4'b1111;
        #1;
        chk("reset_gnt", gnt, 4'b0000);
        req = '0;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single request
        req = 4'b0100; dsts[2] = 5'd8; datas[2] = 32'hDEADBEEF;
        #1;
        chk("single_gnt", gnt, 4'b0100);
        cyc();
        chk("single_rf_we",    rf_we,    1);
        chk("single_rf_waddr", rf_waddr, 8);
        chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_sel",      sel,      2);
        chk("single_conflict", conflict, 0);
        req = '0;

`ifndef REGWRITE_FIXED_PRIO_EN
        // Rotation from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dsts[i]  = 5'(i + 1);
            datas[i] = 32'h100 + 32'(i);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rot_gnt", gnt, exp_rot[i]);
            if (i > 0) begin
                chk("rot_conflict", conflict, 1);
                chk("rot_sel",      sel,      (i - 1) % 4);
            end
            cyc();
        end
        req = '0;

        // $zero filter; pointer still advances
        do_reset();
        req = 4'b0001; dsts[0] = 5'd0;
        #1;
        chk("zero_gnt", gnt, 4'b0001);
        cyc();
        chk("zero_rf_we", rf_we, 0);
        req = 4'b0011; dsts[1] = 5'd7; datas[1] = 32'h12345678;
        #1;
        chk("zero_next_gnt", gnt, 4'b0010);
        cyc();
        chk("zero_next_rf_we",    rf_we,    1);
        chk("zero_next_rf_waddr", rf_waddr, 7);
        chk("zero_next_sel",      sel,      1);
        req = '0;
`endif

        // Idle hold
        req = 4'b1000; dsts[3] = 5'd5; datas[3] = 32'h000000A5;
        #1;
        chk("idle_gnt", gnt, 4'b1000);
        cyc();
        chk("idle_write_we",    rf_we,    1);
        chk("idle_write_waddr", rf_waddr, 5);
        req = '0; dsts[3] = 5'd9; datas[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_rf_we",    rf_we,    0);
            chk("idle_rf_waddr", rf_waddr, 5);
            chk("idle_rf_wdata", rf_wdata, 32'h000000A5);
        end

`ifndef REGWRITE_FIXED_PRIO_EN
        // Reset mid-stream
        for (int i = 0; i < 4; i++) dsts[i] = 5'(i + 10);
        req = 4'b1111;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt",      gnt,      0);
        chk("midrst_rf_we",    rf_we,    0);
        chk("midrst_rf_waddr", rf_waddr, 0);
        chk("midrst_rf_wdata", rf_wdata, 0);
        chk("midrst_sel",      sel,      0);
        chk("midrst_conflict", conflict, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_first_gnt",  gnt,   4'b0001);
        chk("midrst_no_pulse",   rf_we, 0);
        cyc();
        chk("midrst_after_we",    rf_we,    1);
        chk("midrst_after_waddr", rf_waddr, 10);
        req = '0;
`else
        // Fixed priority
        do_reset();
        req = 4'b1010; dsts[1] = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fixed_gnt", gnt, 4'b0010);
            cyc();
        end
        req = '0;
`endif

        // Directed vector table, checked by the model
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++) begin
                dsts[j]  = 5'((i * 7 + j * 3) % 32);
                datas[j] = $urandom;
            end
            req = tbl[i];
            cyc();
        end
        req = '0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
